digit_serial_subtractor: RTL and testbench
==========================================

Name: digit_serial_subtractor

Overview:
- Multi-cycle, digit-serial 64-bit subtractor.
- Computes d = a - b - bi and a final borrow-out. It processes DIGIT bits per clock, LSB digit first.
- This is the inverse datapath to the team's combinational 64-bit ripple-carry adder. It trades latency for area and shares the a/b/carry-style operand convention.
- A start/busy/done handshake lets a controller issue one operation at a time.

Parameters:
- WIDTH, 64, operand and result width in bits.
- DIGIT, 8, bits processed per cycle. Must divide WIDTH evenly; legal values are 1, 2, 4, 8, 16, 32, 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bi  input  1  borrow-in; captured on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- d  output  WIDTH  difference, held until next accepted start
- bo  output  1  borrow-out (1 when a < b+bi, unsigned)
- ov  output  1  signed overflow: sign(a) != sign(b) and sign(d) != sign(a)

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low: it is sampled only on the rising edge of clk.
- Reset: when rst_n=0 at an edge, the block goes to IDLE, the digit counter is 0, and busy=0, done=0, d=0, bo=0, ov=0. Reset mid-operation aborts the operation, with no done pulse.
- States: IDLE, RUN, DONE. K = WIDTH/DIGIT (default 8).
  - IDLE: start=1 at an edge latches a, b and bi into shift registers, clears the counter, and moves to RUN.
  - RUN: each edge computes {borrow_n, diff} = a_dig - b_dig - borrow on the low DIGIT bits, using (DIGIT+1)-bit arithmetic with borrow_n taken from the MSB. The diff digit shifts into the top of the result register; both operand registers shift right by DIGIT; the counter increments. When the counter reaches K-1 at an edge, the state moves to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE. start=1 in the DONE cycle is accepted exactly as in IDLE, enabling back-to-back operations.
- Timing: start is sampled at edge 0. busy is high for cycles 1..K. done is high in cycle K+1 only. d, bo and ov update at the edge ending RUN and hold until the next accepted start.
- Output behaviour during operation:
  - d/bo/ov keep their previous values during RUN; partial results stay internal.
  - After an accepted start, input changes have no effect until done.
  - start while busy=1 is ignored; it is not queued.
- Wrap-around: the result is modulo 2^WIDTH. bo reflects the unsigned underflow of the full WIDTH.
- DIGIT=WIDTH degenerates to K=1: busy is high for one cycle and done follows in the next.

Optional Feature:
- Macro: SUBTRACTOR_ADD_MODE_EN.
- When defined:
  - An extra input port "op" (1 bit) is captured on start. op=1 performs d = a + b + bi, with bo acting as carry-out and ov as the signed add overflow (sign(a)==sign(b) and sign(d) != sign(a)).
  - op=0 behaves as the subtractor above.
  - Timing is identical in both modes.
- When undefined: there is no op port and the block is always a subtractor.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> busy=0, done=0, d=0, bo=0, ov=0. With no start, there is no activity for 20 cycles.
- Basic subtract: a=64'h10, b=64'h3, bi=0, start pulse -> busy high 8 cycles, done in cycle 9, d=64'hD, bo=0, ov=0.
- Underflow/wrap: a=0, b=1, bi=0 -> d=64'hFFFF_FFFF_FFFF_FFFF, bo=1, ov=0. Then a=0, b=0, bi=1 -> same d, bo=1.
- Signed overflow: a=64'h8000_0000_0000_0000, b=1 -> d=64'h7FFF_FFFF_FFFF_FFFF, ov=1, bo=0.
- Handshake: start held high continuously with varying a/b -> new ops accepted only in IDLE/DONE cycles, with done every 9 cycles. Inputs changed mid-RUN do not alter the result.
- Reset mid-op: rst_n=0 in cycle 4 of RUN -> next cycle busy=0, no done pulse, d=0. A fresh start then completes normally. Repeat with DIGIT=1 (done at cycle 65) and DIGIT=64 (done at cycle 2), against a reference model over a 32x32 sweep of a, b.

Source files
------------

// File: rtl/digit_serial_subtractor_if.sv
// Operand/result bundle for the digit-serial subtractor.
// Optional macro SUBTRACTOR_ADD_MODE_EN adds the op select line.
interface digit_serial_subtractor_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
`ifdef SUBTRACTOR_ADD_MODE_EN
    logic             op;

    modport master (output start, a, b, bi, op, input busy, done, d, bo, ov);
    modport slave  (input start, a, b, bi, op, output busy, done, d, bo, ov);
`else
    modport master (output start, a, b, bi, input busy, done, d, bo, ov);
    modport slave  (input start, a, b, bi, output busy, done, d, bo, ov);
`endif
endinterface

// File: rtl/digit_serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor: d = a - b - bi, DIGIT bits per clock,
// LSB digit first, with start/busy/done handshake.
// Optional macro SUBTRACTOR_ADD_MODE_EN: op=1 turns the block into an adder
// (d = a + b + bi, bo = carry-out, ov = signed add overflow).
module digit_serial_subtractor #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    digit_serial_subtractor_if.slave bus
);
    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int DW    = DIGIT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               ov_q, ov_d;

    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               brw_q, brw_d;

    logic               add_mode;
    logic               accept;
    logic               last;
    logic [DIGIT:0]     dig_res;
    logic [WIDTH-1:0]   acc_next;
    logic               ovf;
    logic               a_s, b_s, d_s;

`ifdef SUBTRACTOR_ADD_MODE_EN
    logic               op_q, op_d;
    assign add_mode = op_q;
`else
    assign add_mode = 1'b0;
`endif

    // A new operation may be accepted from IDLE or from the single DONE cycle.
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign last   = (state_q == RUN) && (cnt_q == CNT_W'(K - 1));

    // One digit of the arithmetic; the extra MSB is the borrow (or carry) out.
    always_comb begin
        if (add_mode)
            dig_res = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + DW'(brw_q);
        else
            dig_res = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]} - DW'(brw_q);
        // New digit enters at the top so the LSB digit ends at bit 0 after K steps.
        acc_next = (acc_q >> DIGIT) | (WIDTH'(dig_res[DIGIT-1:0]) << (WIDTH - DIGIT));
        // On the last step the low digit of each shift register holds the sign bit.
        a_s = a_sh_q[DIGIT-1];
        b_s = b_sh_q[DIGIT-1];
        d_s = dig_res[DIGIT-1];
        if (add_mode)
            ovf = (a_s == b_s) && (d_s != a_s);
        else
            ovf = (a_s != b_s) && (d_s != a_s);
    end

    // Next-state logic for the control FSM and the held result outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    d_d     = acc_next;
                    bo_d    = dig_res[DIGIT];
                    ov_d    = ovf;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Next values of the operand shift registers and the partial result.
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        acc_d  = acc_q;
        brw_d  = brw_q;
`ifdef SUBTRACTOR_ADD_MODE_EN
        op_d   = op_q;
`endif
        if (accept) begin
            a_sh_d = bus.a;
            b_sh_d = bus.b;
            brw_d  = bus.bi;
`ifdef SUBTRACTOR_ADD_MODE_EN
            op_d   = bus.op;
`endif
        end else if (state_q == RUN) begin
            a_sh_d = a_sh_q >> DIGIT;
            b_sh_d = b_sh_q >> DIGIT;
            acc_d  = acc_next;
            brw_d  = dig_res[DIGIT];
        end
    end

    // Control state and visible outputs, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
        end
    end

    // Datapath registers; always reloaded on accept, so no reset needed.
    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
        acc_q  <= acc_d;
        brw_q  <= brw_d;
`ifdef SUBTRACTOR_ADD_MODE_EN
        op_q   <= op_d;
`endif
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.ov   = ov_q;
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor with DIGIT = 8, 1 and 64 instances.
// Honours SUBTRACTOR_ADD_MODE_EN when defined.
module tb_digit_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    digit_serial_subtractor_if #(.WIDTH(64)) i8 ();
    digit_serial_subtractor_if #(.WIDTH(64)) i1 ();
    digit_serial_subtractor_if #(.WIDTH(64)) i64 ();

    digit_serial_subtractor #(.WIDTH(64), .DIGIT(8))  u_d8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    digit_serial_subtractor #(.WIDTH(64), .DIGIT(1))  u_d1  (.clk(clk), .rst_n(rst_n), .bus(i1));
    digit_serial_subtractor #(.WIDTH(64), .DIGIT(64)) u_d64 (.clk(clk), .rst_n(rst_n), .bus(i64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {bo, ov, d} from whole-word arithmetic.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic bi, input logic op);
        logic [64:0] r;
        logic        ov;
        if (op) begin
            r  = {1'b0, a} + {1'b0, b} + 65'(bi);
            ov = (a[63] == b[63]) && (r[63] != a[63]);
        end else begin
            r  = {1'b0, a} - {1'b0, b} - 65'(bi);
            ov = (a[63] != b[63]) && (r[63] != a[63]);
        end
        return {r[64], ov, r[63:0]};
    endfunction

    function automatic int k_of(input int w);
        return (w == 0) ? 8 : ((w == 1) ? 64 : 1);
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic rnd_op();
`ifdef SUBTRACTOR_ADD_MODE_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_in(input int w, input logic s, input logic [63:0] a,
                          input logic [63:0] b, input logic bi);
        case (w)
            0: begin i8.start = s;  i8.a = a;  i8.b = b;  i8.bi = bi;  end
            1: begin i1.start = s;  i1.a = a;  i1.b = b;  i1.bi = bi;  end
            default: begin i64.start = s; i64.a = a; i64.b = b; i64.bi = bi; end
        endcase
    endtask

`ifdef SUBTRACTOR_ADD_MODE_EN
    task automatic set_op(input int w, input logic op);
        case (w)
            0: i8.op = op;
            1: i1.op = op;
            default: i64.op = op;
        endcase
    endtask
`endif

    function automatic logic get_busy(input int w);
        return (w == 0) ? i8.busy : ((w == 1) ? i1.busy : i64.busy);
    endfunction
    function automatic logic get_done(input int w);
        return (w == 0) ? i8.done : ((w == 1) ? i1.done : i64.done);
    endfunction
    function automatic logic [63:0] get_d(input int w);
        return (w == 0) ? i8.d : ((w == 1) ? i1.d : i64.d);
    endfunction
    function automatic logic [63:0] get_flags(input int w);
        case (w)
            0: return {62'h0, i8.bo, i8.ov};
            1: return {62'h0, i1.bo, i1.ov};
            default: return {62'h0, i64.bo, i64.ov};
        endcase
    endfunction

    // Issue one operation from a negedge, scramble inputs after acceptance,
    // and check latency, busy length and result. Returns at the done-cycle negedge.
    task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic bi, input logic op, input string tag);
        logic [65:0] exp;
        int          n;
        int          nb;
        bit          seen;
        int          k;
        k   = k_of(w);
        exp = model(a, b, bi, op);
        set_in(w, 1'b1, a, b, bi);
`ifdef SUBTRACTOR_ADD_MODE_EN
        set_op(w, op);
`endif
        @(posedge clk);
        #1;
        set_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, ~bi);
`ifdef SUBTRACTOR_ADD_MODE_EN
        set_op(w, ~op);
`endif
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < k + 4) begin
            @(negedge clk);
            n++;
            if (get_done(w)) seen = 1'b1;
            else if (get_busy(w)) nb++;
        end
        check({tag, "_done_cycle"}, 64'(seen ? n : -1), 64'(k + 1));
        check({tag, "_busy_len"}, 64'(nb), 64'(k));
        check({tag, "_d"}, get_d(w), exp[63:0]);
        check({tag, "_bo_ov"}, get_flags(w), {62'h0, exp[65:64]});
    endtask

    // Reset inside RUN: outputs clear, no done afterwards, fresh op completes.
    task automatic reset_mid_op(input int w, input string tag);
        bit any_done;
        set_in(w, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, 64'h0, 64'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, "_busy"}, 64'(get_busy(w)), 64'h0);
        check({tag, "_done"}, 64'(get_done(w)), 64'h0);
        check({tag, "_d"}, get_d(w), 64'h0);
        check({tag, "_bo_ov"}, get_flags(w), 64'h0);
        any_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            any_done |= get_done(w) | get_busy(w);
        end
        check({tag, "_quiet"}, 64'(any_done), 64'h0);
        do_op(w, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, {tag, "_fresh"});
    endtask

    initial begin
        logic [63:0] oa[0:63];
        logic [63:0] ob[0:63];
        logic        obi[0:63];
        logic [63:0] vals[0:31];
        logic [65:0] exp;
        bit          idle_bad;

        for (int w = 0; w < 3; w++) set_in(w, 1'b0, 64'h0, 64'h0, 1'b0);
`ifdef SUBTRACTOR_ADD_MODE_EN
        for (int w = 0; w < 3; w++) set_op(w, 1'b0);
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("rst%0d_busy", w), 64'(get_busy(w)), 64'h0);
            check($sformatf("rst%0d_done", w), 64'(get_done(w)), 64'h0);
            check($sformatf("rst%0d_d", w), get_d(w), 64'h0);
            check($sformatf("rst%0d_bo_ov", w), get_flags(w), 64'h0);
        end
        idle_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            for (int w = 0; w < 3; w++)
                idle_bad |= get_busy(w) | get_done(w) | (get_d(w) != 64'h0);
        end
        check("idle_quiet", 64'(idle_bad), 64'h0);

        do_op(0, 64'h10, 64'h3, 1'b0, 1'b0, "basic");
        do_op(0, 64'h0, 64'h1, 1'b0, 1'b0, "wrap_b1");
        do_op(0, 64'h0, 64'h0, 1'b1, 1'b0, "wrap_bi");
        do_op(0, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b0, "sovf");
        do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "sovf2");
        check("basic_const_d", 64'h0, 64'h0 ^ (model(64'h10, 64'h3, 1'b0, 1'b0) != 66'hD));

        // start held high: accepts every 9 cycles, mid-run input changes ignored.
        oa[0] = rnd64(); ob[0] = rnd64(); obi[0] = 1'($urandom_range(0, 1));
        set_in(0, 1'b1, oa[0], ob[0], obi[0]);
        @(posedge clk);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            check($sformatf("hs_done_c%0d", c), 64'(get_done(0)), 64'((c % 9) == 0));
            check($sformatf("hs_busy_c%0d", c), 64'(get_busy(0)), 64'((c % 9) != 0));
            if ((c % 9) == 0) begin
                exp = model(oa[c-9], ob[c-9], obi[c-9], 1'b0);
                check($sformatf("hs_d_c%0d", c), get_d(0), exp[63:0]);
                check($sformatf("hs_flags_c%0d", c), get_flags(0), {62'h0, exp[65:64]});
            end
            oa[c] = rnd64(); ob[c] = rnd64(); obi[c] = 1'($urandom_range(0, 1));
            set_in(0, (c != 45), oa[c], ob[c], obi[c]);
            if (c != 45) @(posedge clk);
        end

        reset_mid_op(0, "rmid8");
        for (int i = 0; i < 150; i++)
            do_op(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), rnd_op(), $sformatf("r8_%0d", i));

        for (int i = 0; i < 30; i++)
            do_op(1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), rnd_op(), $sformatf("r1_%0d", i));
        reset_mid_op(1, "rmid1");

        vals[0] = 64'h0;                 vals[1] = 64'h1;
        vals[2] = 64'h2;                 vals[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        vals[4] = 64'hFFFF_FFFF_FFFF_FFFE; vals[5] = 64'h8000_0000_0000_0000;
        vals[6] = 64'h7FFF_FFFF_FFFF_FFFF; vals[7] = 64'h8000_0000_0000_0001;
        for (int i = 8; i < 32; i++) vals[i] = {$urandom, $urandom};
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                do_op(2, vals[i], vals[j], 1'($urandom_range(0, 1)), rnd_op(),
                      $sformatf("sw64_%0d_%0d", i, j));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
